// File: rtl/round_screen_generator_pkg.sv
// Shared constants for the screen-draw logic: FSM encoding, LFSR geometry, screen width.
package game_pkg;
    localparam int SCREEN_W = 2;
    localparam int LFSR_W   = 16;
    // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MAIN = 3'd1;
    localparam logic [2:0] ST_SLOT = 3'd2;
    localparam logic [2:0] ST_FILL = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic [SCREEN_W-1:0] lowest_unused(input logic [3:0] used);
        logic [SCREEN_W-1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--)
            if (!used[i]) r = SCREEN_W'(i);
        return r;
    endfunction
endpackage

// File: rtl/round_screen_generator_if.sv
// Screen-request handshake between the game FSM (master) and the screen generator (slave).
interface round_screen_generator_if;
    import game_pkg::*;
    logic                req;
    logic [SCREEN_W-1:0] first_out;
    logic [SCREEN_W-1:0] second_out;
    logic [SCREEN_W-1:0] third_out;
    logic [SCREEN_W-1:0] fourth_out;
    logic [SCREEN_W-1:0] main_out;
    logic                done;

    modport master (output req, input first_out, second_out, third_out, fourth_out, main_out, done);
    modport slave  (input req, output first_out, second_out, third_out, fourth_out, main_out, done);
endinterface

// File: rtl/round_screen_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR; an all-zero seed would lock up, so it is mapped to 1.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [LFSR_W-1:0] state
);
    localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? LFSR_W'(1) : SEED;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= INIT;
        else     state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? LFSR_TAPS : '0);
    end
endmodule

// File: rtl/round_screen_generator.sv
// Draws a random main screen plus a permutation of {0,1,2,3} for the four bottom screens
// on each accepted request; outputs and done update together when the set is complete.
module round_screen_generator
    import game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                MAX_TRIES = 4
) (
    input  logic CLK,
    input  logic RST,
    round_screen_generator_if.slave scr
);
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    logic [LFSR_W-1:0]   lfsr;
    logic [SCREEN_W-1:0] rnd;
    logic [2:0]          fsm;
    logic                req_q;
    logic                req_rise;
    logic [1:0]          idx;
    logic [3:0]          used;
    logic [TRY_W-1:0]    tries;
    logic [SCREEN_W-1:0] main_r, slot0, slot1, slot2;
    logic [SCREEN_W-1:0] first_r, second_r, third_r, fourth_r, main_out_r;
    logic                done_r;
    logic                take;
    logic [SCREEN_W-1:0] pick;

    lfsr16 #(.SEED(SEED)) u_lfsr (.CLK(CLK), .RST(RST), .state(lfsr));

    assign rnd      = lfsr[SCREEN_W-1:0];
    assign req_rise = scr.req & ~req_q;

    // The last try of a slot is spent on the deterministic fallback, so with
    // MAX_TRIES=1 every slot resolves to the lowest unused value in one cycle.
    always_comb begin
        take = 1'b0;
        pick = rnd;
        if (tries == TRY_LAST) begin
            take = 1'b1;
            pick = lowest_unused(used);
        end else if (!used[rnd]) begin
            take = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fsm        <= ST_IDLE;
            req_q      <= 1'b0;
            idx        <= '0;
            used       <= '0;
            tries      <= '0;
            main_r     <= '0;
            slot0      <= '0;
            slot1      <= '0;
            slot2      <= '0;
            first_r    <= '0;
            second_r   <= '0;
            third_r    <= '0;
            fourth_r   <= '0;
            main_out_r <= '0;
            done_r     <= 1'b0;
        end else begin
            req_q <= scr.req;
            case (fsm)
                ST_IDLE, ST_DONE: begin
                    if (req_rise) begin
                        fsm    <= ST_MAIN;
                        done_r <= 1'b0;
                    end
                end
                ST_MAIN: begin
                    main_r <= rnd;
                    idx    <= '0;
                    used   <= '0;
                    tries  <= '0;
                    fsm    <= ST_SLOT;
                end
                ST_SLOT: begin
                    if (take) begin
                        case (idx)
                            2'd0:    slot0 <= pick;
                            2'd1:    slot1 <= pick;
                            default: slot2 <= pick;
                        endcase
                        used[pick] <= 1'b1;
                        tries      <= '0;
                        idx        <= idx + 2'd1;
                        if (idx == 2'd2) fsm <= ST_FILL;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                ST_FILL: begin
                    first_r    <= slot0;
                    second_r   <= slot1;
                    third_r    <= slot2;
                    fourth_r   <= lowest_unused(used);
                    main_out_r <= main_r;
                    done_r     <= 1'b1;
                    fsm        <= ST_DONE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    assign scr.first_out  = first_r;
    assign scr.second_out = second_r;
    assign scr.third_out  = third_r;
    assign scr.fourth_out = fourth_r;
    assign scr.main_out   = main_out_r;
    assign scr.done       = done_r;
endmodule

// File: tb/tb_round_screen_generator.sv
// Bench for round_screen_generator: one instance with SEED=0/MAX_TRIES=4, one with MAX_TRIES=1.
module tb_round_screen_generator;
    import game_pkg::*;

    typedef struct {
        int         which;
        logic [1:0] main;
        int         lo;
        int         hi;
        logic       fixed;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errs = 0;
    exp_t sb[$];
    logic [15:0] m0, m1;

    always #5 clk = ~clk;

    round_screen_generator_if g0();
    round_screen_generator_if g1();

    round_screen_generator #(.SEED(16'h0000), .MAX_TRIES(4)) dut  (.CLK(clk), .RST(rst), .scr(g0));
    round_screen_generator #(.SEED(16'hACE1), .MAX_TRIES(1)) dut1 (.CLK(clk), .RST(rst), .scr(g1));

    function automatic logic [15:0] step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // reference LFSRs for both instances
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= 16'h0001;
            m1 <= 16'hACE1;
        end else begin
            m0 <= step(m0);
            m1 <= step(m1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic get_done(input int w);
        return (w == 0) ? g0.done : g1.done;
    endfunction

    function automatic logic [9:0] get_all(input int w);
        if (w == 0) return {g0.first_out, g0.second_out, g0.third_out, g0.fourth_out, g0.main_out};
        return {g1.first_out, g1.second_out, g1.third_out, g1.fourth_out, g1.main_out};
    endfunction

    task automatic set_req(input int w, input logic v);
        if (w == 0) g0.req = v;
        else        g1.req = v;
    endtask

    task automatic draw(input int w);
        exp_t       e;
        int         n;
        logic [9:0] s;
        logic [3:0] seen;
        @(negedge clk);
        set_req(w, 1'b1);
        @(posedge clk);
        #1;
        set_req(w, 1'b0);
        chk("done_fall", 32'(get_done(w)), 32'd0);
        e.which = w;
        e.main  = (w == 0) ? m0[1:0] : m1[1:0];
        e.lo    = 5;
        e.hi    = (w == 0) ? 14 : 5;
        e.fixed = (w == 1);
        sb.push_back(e);
        n = 0;
        while (!get_done(w) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        if (!get_done(w)) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("lat_min", 32'(n >= e.lo), 32'd1);
            chk("lat_max", 32'(n <= e.hi), 32'd1);
            s = get_all(e.which);
            chk("main", 32'(s[1:0]), 32'(e.main));
            if (e.fixed) begin
                chk("fallback_set", 32'(s[9:2]), 32'h1B);
            end else begin
                seen = '0;
                for (int i = 0; i < 4; i++) seen[s[2*i+2 +: 2]] = 1'b1;
                chk("perm", 32'(seen), 32'hF);
            end
        end
    endtask

    initial begin
        int   rises;
        logic prev, d;
        g0.req = 1'b0;
        g1.req = 1'b0;

        #12;
        chk("rst_lfsr_seed0", 32'(dut.u_lfsr.state), 32'h0001);
        chk("rst_lfsr_seed", 32'(dut1.u_lfsr.state), 32'hACE1);
        chk("rst_outs0", 32'({get_all(0), get_done(0)}), 32'd0);
        chk("rst_outs1", 32'({get_all(1), get_done(1)}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            chk("lfsr0", 32'(dut.u_lfsr.state), 32'(m0));
            chk("lfsr1", 32'(dut1.u_lfsr.state), 32'(m1));
        end
        chk("idle_outs0", 32'({get_all(0), get_done(0)}), 32'd0);

        repeat (8) draw(1);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(3)) @(negedge clk);
            draw(0);
        end

        // stray pulse during a draw, then a held request: one done rise each
        for (int t = 0; t < 2; t++) begin
            rises = 0;
            prev  = g0.done;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                if (t == 0) g0.req = (i == 0 || i == 2);
                else        g0.req = (i < 3);
                d = g0.done;
                if (d && !prev) rises++;
                prev = d;
            end
            chk(t == 0 ? "stray_req_rises" : "held_req_rises", 32'(rises), 32'd1);
            chk("done_after_ignore", 32'(g0.done), 32'd1);
        end

        // asynchronous reset in the middle of a draw
        @(negedge clk);
        g0.req = 1'b1;
        @(posedge clk);
        #1;
        g0.req = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_outs", 32'({get_all(0), get_done(0)}), 32'd0);
        chk("midrst_lfsr", 32'(dut.u_lfsr.state), 32'h0001);
        chk("midrst_state", 32'(dut.fsm), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        draw(0);
        draw(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end
endmodule
